// File: rtl/fp_pkg.sv
// Shared opcode, ALU-control and state definitions for the FP issue path.
package fp_pkg;

    localparam logic [5:0] OP_FP_R    = 6'h11;
    localparam logic [2:0] OP_FP_I_HI = 3'b110;

    localparam logic [2:0] FP_ADD  = 3'd0;
    localparam logic [2:0] FP_SUB  = 3'd1;
    localparam logic [2:0] FP_MUL  = 3'd2;
    localparam logic [2:0] FP_DIV  = 3'd3;
    localparam logic [2:0] FP_SQRT = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } fp_state_e;

endpackage

// File: rtl/fp_decode.sv
// Pure combinational FP instruction decoder; shared with future hazard logic.
module fp_decode
    import fp_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_fp,
    output logic        legal,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src,
    output logic        reg_dst,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm
);

    logic r_form;
    logic i_form;

    assign r_form = (instr[31:26] == OP_FP_R);
    assign i_form = (instr[31:29] == OP_FP_I_HI);

    assign is_fp    = r_form | i_form;
    assign alu_ctrl = i_form ? instr[28:26] : instr[2:0];
    assign alu_src  = i_form;
    assign reg_dst  = r_form;
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = r_form ? instr[15:11] : 5'd0;
    assign imm      = i_form ? instr[15:0] : 16'd0;

    // R-form reserves funct bits [5:3]; both forms only define ctrl 0..4
    assign legal = (r_form && (instr[5:3] == 3'd0) && (instr[2:0] <= FP_SQRT))
                 || (i_form && (instr[28:26] <= FP_SQRT));

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP decode/issue sequencer: holds FPU controls for the op latency, then
// pulses the register-file write enable once.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        instr_ready,
    output logic        fp_busy,
    output logic [2:0]  fp_alu_ctrl,
    output logic        fp_alu_src,
    output logic        fp_reg_dst,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] immediate,
    output logic        fp_reg_write,
    output logic        illegal
);

    logic        dec_is_fp;
    logic        dec_legal;
    logic [2:0]  dec_ctrl;
    logic        dec_src;
    logic        dec_dst;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [15:0] dec_imm;

    fp_decode u_decode (
        .instr    (instr),
        .is_fp    (dec_is_fp),
        .legal    (dec_legal),
        .alu_ctrl (dec_ctrl),
        .alu_src  (dec_src),
        .reg_dst  (dec_dst),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .rd       (dec_rd),
        .imm      (dec_imm)
    );

    fp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             src_q, src_d;
    logic             dst_q, dst_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       rd_q, rd_d;
    logic [15:0]      imm_q, imm_d;
    logic             illegal_q, illegal_d;

    // Counter holds LAT-1 so that EXEC lasts exactly LAT cycles
    function automatic logic [CNT_W-1:0] lat_load(input logic [2:0] ctrl);
        case (ctrl)
            FP_ADD, FP_SUB: lat_load = CNT_W'(LAT_ADD - 1);
            FP_MUL:         lat_load = CNT_W'(LAT_MUL - 1);
            FP_DIV:         lat_load = CNT_W'(LAT_DIV - 1);
            FP_SQRT:        lat_load = CNT_W'(LAT_SQRT - 1);
            default:        lat_load = '0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        illegal_d    = 1'b0;
        instr_ready  = 1'b0;
        fp_reg_write = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = ~flush;
                if (instr_valid && !flush) begin
                    if (dec_legal) begin
                        ctrl_d  = dec_ctrl;
                        src_d   = dec_src;
                        dst_d   = dec_dst;
                        rs_d    = dec_rs;
                        rt_d    = dec_rt;
                        rd_d    = dec_rd;
                        imm_d   = dec_imm;
                        cnt_d   = lat_load(dec_ctrl);
                        state_d = EXEC;
                    end else if (dec_is_fp) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                // A late flush must still be able to kill this write
                fp_reg_write = ~flush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            src_q     <= 1'b0;
            dst_q     <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign fp_busy     = (state_q != IDLE);
    assign fp_alu_ctrl = ctrl_q;
    assign fp_alu_src  = src_q;
    assign fp_reg_dst  = dst_q;
    assign Rs          = rs_q;
    assign Rt          = rt_q;
    assign Rd          = rd_q;
    assign immediate   = imm_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: accepted legal ops push an expected
// write (cycle + control vector), the write monitor pops and compares.
module tb_fp_issue_ctrl;

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        flush;
    logic        instr_ready;
    logic        fp_busy;
    logic [2:0]  fp_alu_ctrl;
    logic        fp_alu_src;
    logic        fp_reg_dst;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] immediate;
    logic        fp_reg_write;
    logic        illegal;

    fp_issue_ctrl dut (
        .cpu_clk      (cpu_clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .flush        (flush),
        .instr_ready  (instr_ready),
        .fp_busy      (fp_busy),
        .fp_alu_ctrl  (fp_alu_ctrl),
        .fp_alu_src   (fp_alu_src),
        .fp_reg_dst   (fp_reg_dst),
        .Rs           (Rs),
        .Rt           (Rt),
        .Rd           (Rd),
        .immediate    (immediate),
        .fp_reg_write (fp_reg_write),
        .illegal      (illegal)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int          cyc;
        logic [35:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    logic [35:0] ctlVec;
    assign ctlVec = {fp_alu_ctrl, fp_alu_src, fp_reg_dst, Rs, Rt, Rd, immediate};

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [35:0] modelCtl(input logic [31:0] w);
        if (w[31:29] == 3'b110)
            modelCtl = {w[28:26], 1'b1, 1'b0, w[25:21], w[20:16], 5'd0, w[15:0]};
        else
            modelCtl = {w[2:0], 1'b0, 1'b1, w[25:21], w[20:16], w[15:11], 16'd0};
    endfunction

    function automatic bit modelLegal(input logic [31:0] w);
        if (w[31:29] == 3'b110)
            modelLegal = (w[28:26] < 3'd5);
        else if (w[31:26] == 6'h11)
            modelLegal = (w[2:0] < 3'd5) && (w[5:3] == 3'd0);
        else
            modelLegal = 1'b0;
    endfunction

    function automatic int modelLat(input logic [2:0] c);
        case (c)
            3'd0, 3'd1: modelLat = 2;
            3'd2:       modelLat = 3;
            3'd3:       modelLat = 8;
            default:    modelLat = 16;
        endcase
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    // Caller is just past a rising edge; returns just past the accepting edge
    task automatic applyStimulus(input logic [31:0] w, input bit expectWrite,
                                 output int accCyc);
        exp_t e;
        bit   ok;
        ok          = 1'b0;
        accCyc      = -1;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge cpu_clk);
            if (instr_ready) begin
                ok     = 1'b1;
                accCyc = cyc;
                break;
            end
        end
        if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge cpu_clk);
        #1;
        instr_valid = 1'b0;
        if (ok && expectWrite && modelLegal(w)) begin
            e.ctl = modelCtl(w);
            e.cyc = accCyc + modelLat(modelCtl(w)[35:33]) + 1;
            sb.push_back(e);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (rst_n && fp_reg_write) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("write_ctl", 64'(ctlVec), 64'(e.ctl));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        flush       = 1'b0;

        repeat (3) @(posedge cpu_clk);
        #1;
        rst_n = 1'b1;
        @(negedge cpu_clk);
        checkOutput("rst_ready", 64'(instr_ready), 64'd1);
        checkOutput("rst_busy", 64'(fp_busy), 64'd0);
        checkOutput("rst_write", 64'(fp_reg_write), 64'd0);
        checkOutput("rst_illegal", 64'(illegal), 64'd0);
        checkOutput("rst_ctl", 64'(ctlVec), 64'd0);

        // R-form add
        @(posedge cpu_clk);
        #1;
        applyStimulus(32'h44221800, 1'b1, acc);
        checkOutput("radd_ctl", 64'(ctlVec),
                    64'({3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 16'd0}));
        for (int k = 1; k <= 2; k++) begin
            @(negedge cpu_clk);
            checkOutput("radd_busy", 64'(fp_busy), 64'd1);
            checkOutput("radd_ready", 64'(instr_ready), 64'd0);
            checkOutput("radd_nowrite", 64'(fp_reg_write), 64'd0);
        end
        while (cyc < acc + 4) waitCycles(1);
        @(negedge cpu_clk);
        checkOutput("radd_ready_again", 64'(instr_ready), 64'd1);
        checkOutput("radd_idle_hold", 64'(ctlVec),
                    64'({3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 16'd0}));

        // I-form add
        @(posedge cpu_clk);
        #1;
        applyStimulus(32'hC0244000, 1'b1, acc);
        checkOutput("iadd_ctl", 64'(ctlVec),
                    64'({3'd0, 1'b1, 1'b0, 5'd1, 5'd4, 5'd0, 16'h4000}));
        waitCycles(4);

        // Sqrt with a second op held valid throughout
        applyStimulus(32'h44221804, 1'b1, acc);
        fork
            applyStimulus(32'h44A61802, 1'b1, acc2);
            begin
                for (int k = 1; k <= 17; k++) begin
                    @(negedge cpu_clk);
                    checkOutput("sqrt_hold", 64'(ctlVec), 64'(modelCtl(32'h44221804)));
                    checkOutput("sqrt_busy", 64'(fp_busy), 64'd1);
                end
            end
        join
        checkOutput("bp_accept_cycle", 64'(acc2), 64'(acc + 18));
        waitCycles(6);

        // Illegal ctrl, illegal funct, illegal I-form ctrl
        applyStimulus(32'h44221806, 1'b1, acc);
        checkOutput("ill6_pulse", 64'(illegal), 64'd1);
        checkOutput("ill6_busy", 64'(fp_busy), 64'd0);
        waitCycles(1);
        checkOutput("ill6_pulse_end", 64'(illegal), 64'd0);
        applyStimulus(32'h44221808, 1'b1, acc);
        checkOutput("ill_funct_pulse", 64'(illegal), 64'd1);
        checkOutput("ill_funct_busy", 64'(fp_busy), 64'd0);
        applyStimulus(32'hD4244000, 1'b1, acc);
        checkOutput("ill_iform_pulse", 64'(illegal), 64'd1);

        // Non-FP opcode
        applyStimulus(32'h00000000, 1'b1, acc);
        checkOutput("nonfp_illegal", 64'(illegal), 64'd0);
        checkOutput("nonfp_busy", 64'(fp_busy), 64'd0);

        // Flush during sqrt EXEC at cycle 5
        waitCycles(1);
        applyStimulus(32'h44221804, 1'b0, acc);
        while (cyc < acc + 5) waitCycles(1);
        flush = 1'b1;
        @(negedge cpu_clk);
        checkOutput("flush_exec_busy", 64'(fp_busy), 64'd1);
        @(posedge cpu_clk);
        #1;
        flush = 1'b0;
        @(negedge cpu_clk);
        checkOutput("flush_exec_ready", 64'(instr_ready), 64'd1);
        checkOutput("flush_exec_idle", 64'(fp_busy), 64'd0);

        // Flush in the WB cycle masks the write
        @(posedge cpu_clk);
        #1;
        applyStimulus(32'h44221800, 1'b0, acc);
        while (cyc < acc + 3) waitCycles(1);
        flush = 1'b1;
        @(negedge cpu_clk);
        checkOutput("flush_wb_write", 64'(fp_reg_write), 64'd0);
        checkOutput("flush_wb_busy", 64'(fp_busy), 64'd1);
        @(posedge cpu_clk);
        #1;
        checkOutput("flush_wb_ready", 64'(instr_ready), 64'd0);
        flush = 1'b0;
        @(negedge cpu_clk);
        checkOutput("flush_wb_idle", 64'(fp_busy), 64'd0);

        // Flush in IDLE drops a simultaneous instruction
        @(posedge cpu_clk);
        #1;
        flush       = 1'b1;
        instr       = 32'h44221800;
        instr_valid = 1'b1;
        @(negedge cpu_clk);
        checkOutput("flush_idle_ready", 64'(instr_ready), 64'd0);
        @(posedge cpu_clk);
        #1;
        flush       = 1'b0;
        instr_valid = 1'b0;
        @(negedge cpu_clk);
        checkOutput("flush_idle_dropped", 64'(fp_busy), 64'd0);

        // Async reset in cycle 2 of a div
        @(posedge cpu_clk);
        #1;
        applyStimulus(32'h44221803, 1'b0, acc);
        while (cyc < acc + 2) waitCycles(1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(fp_busy), 64'd0);
        checkOutput("arst_ready", 64'(instr_ready), 64'd1);
        checkOutput("arst_ctl", 64'(ctlVec), 64'd0);
        checkOutput("arst_write", 64'(fp_reg_write), 64'd0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(12);
        checkOutput("arst_still_idle", 64'(fp_busy), 64'd0);

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
